// File: rtl/sdcard_spi_ctrl.sv
// SD card SPI master (mode 0, MSB first) behind an 8-bit CPU register window.
// Optional CRC7 trailer generator is enabled by defining SDCARD_SPI_CRC7_EN.
`timescale 1ns/1ps
module sdcard_spi_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd124
) (
  input  logic       clk,
  input  logic       nrst,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  input  logic [5:0] addr,
  input  logic       cs,
  input  logic       oe,
  input  logic       we,
  output logic       sdcard_sck,
  output logic       sdcard_mosi,
  input  logic       sdcard_miso,
  output logic       sdcard_cs_n
);

  localparam logic [5:0] AddrSpdr = 6'h10;
  localparam logic [5:0] AddrSpsr = 6'h11;
  localparam logic [5:0] AddrSpcr = 6'h12;
  localparam logic [5:0] AddrSpbr = 6'h13;
  localparam logic [5:0] AddrCrc  = 6'h14;

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  state_e     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] spbr_q, spbr_d;
  logic       spif_q, spif_d;
  logic       wcol_q, wcol_d;
  logic       cs_n_q, cs_n_d;
  logic       mosi_q, mosi_d;
`ifdef SDCARD_SPI_CRC7_EN
  logic [6:0] crc_q, crc_d;
`endif

  logic busy, wr, rd, spdr_wr, spdr_rd, start, bit_done, last_bit;

  // Bus decode and transfer sequencing.
  always_comb begin
    busy      = (state_q != StIdle);
    wr        = cs && we;
    rd        = cs && oe;
    spdr_wr   = wr && (addr == AddrSpdr);
    spdr_rd   = rd && (addr == AddrSpdr);
    start     = spdr_wr && !busy;
    bit_done  = 1'b0;
    last_bit  = 1'b0;
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    mosi_d    = mosi_q;
    spbr_d    = spbr_q;
    cs_n_d    = cs_n_q;
    spif_d    = spif_q;
    wcol_d    = wcol_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLow;
          shift_d   = data_in;
          mosi_d    = data_in[7];
          div_cnt_d = spbr_q;
          bit_cnt_d = 3'd0;
        end
      end
      StLow: begin
        if (div_cnt_q == 8'd0) begin
          state_d   = StHigh;
          div_cnt_d = spbr_q;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      StHigh: begin
        if (div_cnt_q == 8'd0) begin
          // End of high phase: sample MISO here.
          bit_done  = 1'b1;
          shift_d   = {shift_q[6:0], sdcard_miso};
          bit_cnt_d = bit_cnt_q + 3'd1;
          div_cnt_d = spbr_q;
          if (bit_cnt_q == 3'd7) begin
            last_bit = 1'b1;
            rx_d     = {shift_q[6:0], sdcard_miso};
            state_d  = StIdle;
            mosi_d   = 1'b1;
          end else begin
            state_d = StLow;
            mosi_d  = shift_q[6];
          end
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flag updates: clears first so that a same-cycle set wins.
    if (spdr_rd || start) begin
      spif_d = 1'b0;
      wcol_d = 1'b0;
    end
    if (spdr_wr && busy) wcol_d = 1'b1;
    if (last_bit)        spif_d = 1'b1;

    if (wr && (addr == AddrSpcr)) cs_n_d = data_in[0];
    if (wr && (addr == AddrSpbr)) spbr_d = data_in;
  end

`ifdef SDCARD_SPI_CRC7_EN
  // CRC7 (x^7+x^3+1) over transmitted bits; a CPU write clears it and wins.
  always_comb begin
    crc_d = crc_q;
    if (bit_done) begin
      crc_d = {crc_q[5:0], 1'b0} ^ ({7{crc_q[6] ^ shift_q[7]}} & 7'h09);
    end
    if (wr && (addr == AddrCrc)) crc_d = 7'd0;
  end
`endif

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= StIdle;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      rx_q      <= 8'd0;
      spbr_q    <= DIV_RESET;
      spif_q    <= 1'b0;
      wcol_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b1;
`ifdef SDCARD_SPI_CRC7_EN
      crc_q     <= 7'd0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      spbr_q    <= spbr_d;
      spif_q    <= spif_d;
      wcol_q    <= wcol_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
`ifdef SDCARD_SPI_CRC7_EN
      crc_q     <= crc_d;
`endif
    end
  end

  // Combinational read mux, forced to zero unless a mapped register is read.
  always_comb begin
    data_out = 8'h00;
    if (nrst && cs && oe) begin
      case (addr)
        AddrSpdr: data_out = rx_q;
        AddrSpsr: data_out = {spif_q, wcol_q, 5'b0, busy};
        AddrSpcr: data_out = {7'b0, cs_n_q};
        AddrSpbr: data_out = spbr_q;
`ifdef SDCARD_SPI_CRC7_EN
        AddrCrc:  data_out = {crc_q, 1'b1};
`endif
        default:  data_out = 8'h00;
      endcase
    end
  end

  assign sdcard_sck  = (state_q == StHigh);
  assign sdcard_mosi = mosi_q;
  assign sdcard_cs_n = cs_n_q;

endmodule

// File: tb/tb_sdcard_spi_ctrl.sv
// Self-checking bench for sdcard_spi_ctrl: register table, SPI transfers
// against a byte-level card/timing model, and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_sdcard_spi_ctrl;

  localparam logic [7:0] DivReset = 8'd124;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] data_out, data_in;
  logic [5:0] addr;
  logic       cs, oe, we;
  logic       sdcard_sck, sdcard_mosi, sdcard_miso, sdcard_cs_n;

  int checks = 0;
  int errors = 0;

  sdcard_spi_ctrl #(.DIV_RESET(DivReset)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .data_out    (data_out),
    .data_in     (data_in),
    .addr        (addr),
    .cs          (cs),
    .oe          (oe),
    .we          (we),
    .sdcard_sck  (sdcard_sck),
    .sdcard_mosi (sdcard_mosi),
    .sdcard_miso (sdcard_miso),
    .sdcard_cs_n (sdcard_cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic [5:0] waddr;
    logic [7:0] wdata;
    logic [5:0] raddr;
    logic [7:0] exp;
    logic       exp_cs_n;
  } vec_t;

  vec_t vecs[14];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference CRC7 over a whole byte, MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] b);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ b[i];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  task automatic write_reg(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; oe = 1'b0; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic read_reg(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; oe = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_out;
    @(posedge clk);
    #1;
    cs = 1'b0; oe = 1'b0;
  endtask

  // One byte exchange. The bench plays the card (shifting out `card` after
  // each falling sck) and checks timing, MOSI stream and flags from the
  // byte-level rules. An optional bus write is injected at cycle act_cyc.
  task automatic do_transfer(input logic [7:0] tx, input logic [7:0] card,
                             input logic [7:0] div, input int act_cyc,
                             input logic [5:0] act_addr, input logic [7:0] act_data);
    int         busy_cyc, high_cyc, pulses, falls;
    logic [7:0] got, spsr, v;
    logic       prev, restore, cs_chk, exp_wcol;
    busy_cyc = 0; high_cyc = 0; pulses = 0; falls = 0;
    got = 8'h00; spsr = 8'h00; prev = 1'b0; restore = 1'b0; cs_chk = 1'b0;
    exp_wcol = (act_cyc > 0) && (act_addr == 6'h10);
    write_reg(6'h13, div);
    sdcard_miso = card[7];
    write_reg(6'h10, tx);
    cs = 1'b1; oe = 1'b1; we = 1'b0; addr = 6'h11;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      @(negedge clk);
      if (restore) begin
        we = 1'b0; oe = 1'b1; addr = 6'h11; restore = 1'b0;
      end
      #1;
      if (cs_chk) begin
        check8("cs_n_mid_xfer", {7'b0, sdcard_cs_n}, {7'b0, act_data[0]});
        cs_chk = 1'b0;
      end
      spsr = data_out;
      if (!spsr[0]) break;
      busy_cyc++;
      if (sdcard_sck) high_cyc++;
      if (sdcard_sck && !prev) begin
        pulses++;
        got = {got[6:0], sdcard_mosi};
      end
      if (!sdcard_sck && prev) begin
        falls++;
        if (falls < 8) sdcard_miso = card[7-falls];
      end
      prev = sdcard_sck;
      if (cyc == act_cyc) begin
        oe = 1'b0; we = 1'b1; addr = act_addr; data_in = act_data;
        restore = 1'b1;
        cs_chk  = (act_addr == 6'h12);
      end
    end
    checkn("busy_cycles", busy_cyc, 16 * (int'(div) + 1));
    checkn("sck_high_cycles", high_cyc, 8 * (int'(div) + 1));
    checkn("sck_pulses", pulses, 8);
    check8("mosi_byte", got, tx);
    check8("spsr_done", spsr, {1'b1, exp_wcol, 6'b0});
    check8("idle_pins", {6'b0, sdcard_sck, sdcard_mosi}, 8'h01);
    @(posedge clk);
    #1;
    cs = 1'b0; oe = 1'b0; we = 1'b0;
    read_reg(6'h10, v);
    check8("spdr_rx", v, card);
    read_reg(6'h11, v);
    check8("spsr_after_read", v, 8'h00);
  endtask

  logic [7:0] v;
  logic [7:0] rtx, rcard, rdiv;
  logic [6:0] crc_ref;
  logic [7:0] cmd_a[5];
  logic [7:0] cmd_b[5];

  initial begin
    nrst = 1'b0; cs = 1'b0; oe = 1'b0; we = 1'b0; addr = 6'h00; data_in = 8'h00;
    sdcard_miso = 1'b1;
    crc_ref = 7'd0;
    cmd_a = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    cmd_b = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};

    vecs[0]  = '{1'b0, 6'h00, 8'h00, 6'h11, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 6'h00, 8'h00, 6'h12, 8'h01, 1'b1};
    vecs[2]  = '{1'b0, 6'h00, 8'h00, 6'h13, DivReset, 1'b1};
    vecs[3]  = '{1'b0, 6'h00, 8'h00, 6'h10, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 6'h12, 8'h00, 6'h12, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 6'h12, 8'hFE, 6'h12, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 6'h12, 8'hFF, 6'h12, 8'h01, 1'b1};
    vecs[7]  = '{1'b1, 6'h13, 8'h5A, 6'h13, 8'h5A, 1'b1};
    vecs[8]  = '{1'b1, 6'h15, 8'h33, 6'h13, 8'h5A, 1'b1};
    vecs[9]  = '{1'b1, 6'h00, 8'hFE, 6'h12, 8'h01, 1'b1};
    vecs[10] = '{1'b0, 6'h00, 8'h00, 6'h3F, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 6'h11, 8'hFF, 6'h11, 8'h00, 1'b1};
`ifdef SDCARD_SPI_CRC7_EN
    vecs[12] = '{1'b0, 6'h00, 8'h00, 6'h14, 8'h01, 1'b1};
    vecs[13] = '{1'b1, 6'h14, 8'hFF, 6'h14, 8'h01, 1'b1};
`else
    vecs[12] = '{1'b0, 6'h00, 8'h00, 6'h14, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 6'h14, 8'hFF, 6'h14, 8'h00, 1'b1};
`endif

    // Reset state of the pins.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("reset_pins", {5'b0, sdcard_sck, sdcard_mosi, sdcard_cs_n}, 8'h03);
    nrst = 1'b1;

    // Register table.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wen) write_reg(vecs[i].waddr, vecs[i].wdata);
      read_reg(vecs[i].raddr, v);
      check8($sformatf("vec%0d_read", i), v, vecs[i].exp);
      check8($sformatf("vec%0d_cs_n", i), {7'b0, sdcard_cs_n}, {7'b0, vecs[i].exp_cs_n});
    end

    // Read qualification by cs and oe.
    @(negedge clk);
    cs = 1'b0; oe = 1'b1; addr = 6'h13;
    #1;
    check8("read_no_cs", data_out, 8'h00);
    cs = 1'b1; oe = 1'b0;
    #1;
    check8("read_no_oe", data_out, 8'h00);
    cs = 1'b0;

    // Basic transfer at full speed, then WCOL collision, then CS_N mid-transfer.
    do_transfer(8'hA5, 8'h3C, 8'd0, 0, 6'h00, 8'h00);
    do_transfer(8'hFF, 8'h81, 8'd3, 5, 6'h10, 8'h00);
    do_transfer(8'hC3, 8'h5A, 8'd1, 3, 6'h12, 8'h00);
    do_transfer(8'h3C, 8'hA5, 8'd1, 6, 6'h12, 8'h01);

    // SPDR read on the completion cycle: SPIF set must win.
    write_reg(6'h13, 8'd0);
    sdcard_miso = 1'b0;
    write_reg(6'h10, 8'h11);
    repeat (15) @(negedge clk);
    read_reg(6'h10, v);
    read_reg(6'h11, v);
    check8("spif_set_wins", v, 8'h80);
    read_reg(6'h10, v);
    check8("spif_case_rx", v, 8'h00);
    read_reg(6'h11, v);
    check8("spif_case_clear", v, 8'h00);

    // Reset in the middle of a transfer.
    write_reg(6'h13, 8'd3);
    write_reg(6'h10, 8'h55);
    repeat (6) @(negedge clk);
    @(negedge clk);
    nrst = 1'b0; cs = 1'b1; oe = 1'b1; addr = 6'h11;
    #1;
    check8("read_gated_by_nrst", data_out, 8'h00);
    @(negedge clk);
    check8("abort_pins", {5'b0, sdcard_sck, sdcard_mosi, sdcard_cs_n}, 8'h03);
    nrst = 1'b1; cs = 1'b0; oe = 1'b0;
    read_reg(6'h11, v);
    check8("abort_spsr", v, 8'h00);
    read_reg(6'h10, v);
    check8("abort_spdr", v, 8'h00);
    read_reg(6'h13, v);
    check8("abort_spbr", v, DivReset);
    do_transfer(8'h96, 8'h69, 8'd2, 0, 6'h00, 8'h00);

    // Randomized transfers against the byte-level model.
`ifdef SDCARD_SPI_CRC7_EN
    write_reg(6'h14, 8'h00);
`endif
    crc_ref = 7'd0;
    for (int i = 0; i < 12; i++) begin
      rtx   = 8'($urandom);
      rcard = 8'($urandom);
      rdiv  = 8'($urandom_range(0, 6));
      do_transfer(rtx, rcard, rdiv, 0, 6'h00, 8'h00);
      crc_ref = crc7_byte(crc_ref, rtx);
    end
`ifdef SDCARD_SPI_CRC7_EN
    read_reg(6'h14, v);
    check8("crc_random", v, {crc_ref, 1'b1});

    // Known SD command trailers.
    write_reg(6'h14, 8'h00);
    for (int i = 0; i < 5; i++) do_transfer(cmd_a[i], 8'hFF, 8'd0, 0, 6'h00, 8'h00);
    read_reg(6'h14, v);
    check8("crc_cmd0", v, 8'h95);
    write_reg(6'h14, 8'h00);
    for (int i = 0; i < 5; i++) do_transfer(cmd_b[i], 8'hFF, 8'd0, 0, 6'h00, 8'h00);
    read_reg(6'h14, v);
    check8("crc_cmd8", v, 8'h87);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
